// File: rtl/fifo_access_arbiter_if.sv
// Requester and FIFO-side signal bundle for fifo_access_arbiter.
// The master side drives requests and the FIFO read word; the slave side is the arbiter.
interface fifo_access_arbiter_if #(
  parameter int unsigned BIT_DEPTH = 32,
  parameter int unsigned CNT_W     = 5
);
  logic                 a_req;
  logic                 a_wr;
  logic [BIT_DEPTH-1:0] a_wdata;
  logic                 a_ack;
  logic                 a_err;
  logic                 b_req;
  logic                 b_wr;
  logic [BIT_DEPTH-1:0] b_wdata;
  logic                 b_ack;
  logic                 b_err;
  logic [BIT_DEPTH-1:0] rd_data;
  logic                 fifo_wr_en;
  logic [BIT_DEPTH-1:0] fifo_wr_data;
  logic                 fifo_rd_en;
  logic [BIT_DEPTH-1:0] fifo_rd_data;
  logic [CNT_W-1:0]     count;
  logic                 full;
  logic                 empty;

  modport master (
    output a_req, a_wr, a_wdata, b_req, b_wr, b_wdata, fifo_rd_data,
    input  a_ack, a_err, b_ack, b_err, rd_data, fifo_wr_en, fifo_wr_data,
    input  fifo_rd_en, count, full, empty
  );

  modport slave (
    input  a_req, a_wr, a_wdata, b_req, b_wr, b_wdata, fifo_rd_data,
    output a_ack, a_err, b_ack, b_err, rd_data, fifo_wr_en, fifo_wr_data,
    output fifo_rd_en, count, full, empty
  );
endinterface

// File: rtl/fifo_access_arbiter.sv
// Round-robin two-requester access controller for a single FIFO.
// Owns the FIFO strobes and occupancy count; rejects writes when full and reads when empty.
module fifo_access_arbiter #(
  parameter int unsigned BIT_DEPTH  = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  fifo_access_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    RD_ACK  = 3'd4,
    REJ     = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 win_b_q, win_b_d;
  logic                 prio_b_q, prio_b_d;
  logic                 a_ack_q, a_ack_d, a_err_q, a_err_d;
  logic                 b_ack_q, b_ack_d, b_err_q, b_err_d;
  logic [BIT_DEPTH-1:0] rd_data_q, rd_data_d;
  logic                 wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [BIT_DEPTH-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, full_d, empty_q, empty_d;
  logic                 pick_b, sel_wr;
  logic [BIT_DEPTH-1:0] sel_wdata;

  // Next-state and next-output decode; every registered output is computed here.
  always_comb begin
    state_d   = state_q;
    win_b_d   = win_b_q;
    prio_b_d  = prio_b_q;
    a_ack_d   = 1'b0;
    a_err_d   = 1'b0;
    b_ack_d   = 1'b0;
    b_err_d   = 1'b0;
    rd_data_d = rd_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    count_d   = count_q;
    pick_b    = bus.b_req && (!bus.a_req || prio_b_q);
    sel_wr    = pick_b ? bus.b_wr : bus.a_wr;
    sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;

    case (state_q)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          win_b_d = pick_b;
          // Pointer only moves when both requesters competed for this grant.
          if (bus.a_req && bus.b_req) prio_b_d = !pick_b;
          if ((sel_wr && full_q) || (!sel_wr && empty_q)) begin
            state_d = REJ;
            a_ack_d = !pick_b;
            a_err_d = !pick_b;
            b_ack_d = pick_b;
            b_err_d = pick_b;
          end else if (sel_wr) begin
            state_d   = WR;
            wr_en_d   = 1'b1;
            wr_data_d = sel_wdata;
            a_ack_d   = !pick_b;
            b_ack_d   = pick_b;
          end else begin
            state_d = RD;
            rd_en_d = 1'b1;
          end
        end
      end
      WR: begin
        state_d = IDLE;
        count_d = count_q + CNT_W'(1);
      end
      RD: begin
        state_d = RD_WAIT;
        count_d = count_q - CNT_W'(1);
      end
      RD_WAIT: begin
        state_d   = RD_ACK;
        rd_data_d = bus.fifo_rd_data;
        a_ack_d   = !win_b_q;
        b_ack_d   = win_b_q;
      end
      RD_ACK:  state_d = IDLE;
      REJ:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    full_d  = (count_d == CNT_W'(FIFO_DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_b_q   <= 1'b0;
      prio_b_q  <= 1'b0;
      a_ack_q   <= 1'b0;
      a_err_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      b_err_q   <= 1'b0;
      rd_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_data_q <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      win_b_q   <= win_b_d;
      prio_b_q  <= prio_b_d;
      a_ack_q   <= a_ack_d;
      a_err_q   <= a_err_d;
      b_ack_q   <= b_ack_d;
      b_err_q   <= b_err_d;
      rd_data_q <= rd_data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      wr_data_q <= wr_data_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
    end
  end

  assign bus.a_ack        = a_ack_q;
  assign bus.a_err        = a_err_q;
  assign bus.b_ack        = b_ack_q;
  assign bus.b_err        = b_err_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign bus.fifo_rd_en   = rd_en_q;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Directed bench for fifo_access_arbiter with a behavioural FIFO behind the strobes.
// Expected values are hand-derived from the arbitration and timing rules.
module tb_fifo_access_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   excl_err;
  logic [31:0] fifo_q[$];

  fifo_access_arbiter_if #(.BIT_DEPTH(32), .CNT_W(5)) bus ();

  fifo_access_arbiter #(.BIT_DEPTH(32), .FIFO_DEPTH(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: read word valid the cycle after the strobe.
  always @(posedge clk) begin
    if (!rst_n) begin
      fifo_q.delete();
      bus.fifo_rd_data <= '0;
    end else begin
      if (bus.fifo_wr_en) fifo_q.push_back(bus.fifo_wr_data);
      if (bus.fifo_rd_en && fifo_q.size() > 0) bus.fifo_rd_data <= fifo_q.pop_front();
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.a_ack && bus.b_ack) excl_err++;
      if (bus.fifo_wr_en && bus.fifo_rd_en) excl_err++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request, hold it until ack (bounded), then release it.
  task automatic req_op(input bit use_b, input bit wr, input logic [31:0] d,
                        output bit err, output logic [31:0] rdat, output int lat,
                        output bit saw_wr, output bit saw_rd, output logic [31:0] wdat);
    err = 1'b0; rdat = '0; lat = 0; saw_wr = 1'b0; saw_rd = 1'b0; wdat = '0;
    if (use_b) begin
      bus.b_wr = wr; bus.b_wdata = d; bus.b_req = 1'b1;
    end else begin
      bus.a_wr = wr; bus.a_wdata = d; bus.a_req = 1'b1;
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.fifo_wr_en) begin saw_wr = 1'b1; wdat = bus.fifo_wr_data; end
      if (bus.fifo_rd_en) saw_rd = 1'b1;
      if (use_b ? bus.b_ack : bus.a_ack) begin
        lat  = i;
        err  = use_b ? bus.b_err : bus.a_err;
        rdat = bus.rd_data;
        break;
      end
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    if (lat == 0) check("ack_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input bit use_b, input logic [31:0] d, input bit exp_err, input string tag);
    bit err, sw, sr; logic [31:0] rd, wd; int lat;
    req_op(use_b, 1'b1, d, err, rd, lat, sw, sr, wd);
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_lat"}, 64'(lat), 64'd1);
    check({tag, "_wr_en"}, 64'(sw), 64'(!exp_err));
    check({tag, "_rd_en"}, 64'(sr), 64'd0);
    if (!exp_err) check({tag, "_wdata"}, 64'(wd), 64'(d));
  endtask

  task automatic do_read(input bit use_b, input bit exp_err, input logic [31:0] exp_d, input string tag);
    bit err, sw, sr; logic [31:0] rd, wd; int lat;
    req_op(use_b, 1'b0, 32'h0, err, rd, lat, sw, sr, wd);
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_lat"}, 64'(lat), exp_err ? 64'd1 : 64'd3);
    check({tag, "_rd_en"}, 64'(sr), 64'(!exp_err));
    check({tag, "_wr_en"}, 64'(sw), 64'd0);
    if (!exp_err) check({tag, "_rdata"}, 64'(rd), 64'(exp_d));
  endtask

  // Both requesters raise writes together; each drops on its own ack.
  task automatic contend(input logic [31:0] da, input logic [31:0] db, input bit b_first, input string tag);
    int a_cyc, b_cyc, n;
    logic [31:0] wlog [2];
    a_cyc = 0; b_cyc = 0; n = 0;
    wlog[0] = '0; wlog[1] = '0;
    bus.a_wr = 1'b1; bus.a_wdata = da; bus.a_req = 1'b1;
    bus.b_wr = 1'b1; bus.b_wdata = db; bus.b_req = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (bus.fifo_wr_en && n < 2) begin wlog[n] = bus.fifo_wr_data; n++; end
      if (bus.a_ack) begin a_cyc = i; bus.a_req = 1'b0; end
      if (bus.b_ack) begin b_cyc = i; bus.b_req = 1'b0; end
      if (a_cyc != 0 && b_cyc != 0) break;
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    check({tag, "_a_cyc"}, 64'(a_cyc), b_first ? 64'd3 : 64'd1);
    check({tag, "_b_cyc"}, 64'(b_cyc), b_first ? 64'd1 : 64'd3);
    check({tag, "_nwr"}, 64'(n), 64'd2);
    check({tag, "_first"}, 64'(wlog[0]), b_first ? 64'(db) : 64'(da));
    check({tag, "_second"}, 64'(wlog[1]), b_first ? 64'(da) : 64'(db));
    @(posedge clk); #1;
  endtask

  initial begin
    int act;
    checks = 0; errors = 0; excl_err = 0;
    rst_n = 1'b0;
    bus.a_req = 1'b0; bus.a_wr = 1'b0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_wr = 1'b0; bus.b_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_rd_data", 64'(bus.rd_data), 64'd0);
    check("rst_wr_data", 64'(bus.fifo_wr_data), 64'd0);
    rst_n = 1'b1;

    act = 0;
    repeat (6) begin
      @(posedge clk); #1;
      act += int'(bus.a_ack) + int'(bus.b_ack) + int'(bus.fifo_wr_en) + int'(bus.fifo_rd_en);
    end
    check("idle_activity", 64'(act), 64'd0);
    check("idle_empty", 64'(bus.empty), 64'd1);

    do_read(1'b0, 1'b1, 32'h0, "empty_rd");
    check("empty_rd_count", 64'(bus.count), 64'd0);

    do_write(1'b0, 32'hDEADBEEF, 1'b0, "wr1");
    check("wr1_count", 64'(bus.count), 64'd1);
    check("wr1_empty", 64'(bus.empty), 64'd0);
    do_read(1'b0, 1'b0, 32'hDEADBEEF, "rd1");
    check("rd1_count", 64'(bus.count), 64'd0);
    check("rd1_empty", 64'(bus.empty), 64'd1);

    contend(32'h1, 32'h2, 1'b0, "pair1");
    contend(32'h3, 32'h4, 1'b1, "pair2");
    check("pairs_count", 64'(bus.count), 64'd4);
    check("rd_data_hold", 64'(bus.rd_data), 64'hDEADBEEF);

    for (int i = 0; i < 12; i++) do_write(1'b1, 32'h100 + 32'(i), 1'b0, "fill");
    check("fill_count", 64'(bus.count), 64'd16);
    check("fill_full", 64'(bus.full), 64'd1);
    check("fill_empty", 64'(bus.empty), 64'd0);
    do_write(1'b0, 32'hBAD, 1'b1, "overflow");
    check("overflow_count", 64'(bus.count), 64'd16);
    do_read(1'b1, 1'b0, 32'h1, "first_out");
    check("first_out_count", 64'(bus.count), 64'd15);
    check("first_out_full", 64'(bus.full), 64'd0);

    // Reset lands during RD_WAIT; the read must vanish without an ack.
    bus.a_wr = 1'b0; bus.a_req = 1'b1;
    @(posedge clk); #1;
    check("mid_rd_strobe", 64'(bus.fifo_rd_en), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    bus.a_req = 1'b0;
    check("mid_rst_ack", 64'(bus.a_ack), 64'd0);
    check("mid_rst_count", 64'(bus.count), 64'd0);
    check("mid_rst_empty", 64'(bus.empty), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    act = 0;
    repeat (4) begin
      @(posedge clk); #1;
      act += int'(bus.a_ack) + int'(bus.b_ack) + int'(bus.fifo_wr_en) + int'(bus.fifo_rd_en);
    end
    check("post_rst_quiet", 64'(act), 64'd0);
    do_write(1'b0, 32'h55, 1'b0, "post_wr");
    check("post_wr_count", 64'(bus.count), 64'd1);
    do_read(1'b0, 1'b0, 32'h55, "post_rd");
    check("post_rd_count", 64'(bus.count), 64'd0);

    check("mutex", 64'(excl_err), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
